// File: rtl/score_pkg.sv
// score_pkg: shared definitions for the multi-team score register.
//   PTS_*          : add_pts code values
//   TEAM_IDX_W     : team field width stored in a history entry (up to 256 teams)
//   hist_entry_t   : undo history entry {team, applied delta}
//   team_idx_w()   : width of a team index for a given team count
package score_pkg;

  localparam logic [1:0] PTS_NONE  = 2'd0;
  localparam logic [1:0] PTS_ONE   = 2'd1;
  localparam logic [1:0] PTS_TWO   = 2'd2;
  localparam logic [1:0] PTS_THREE = 2'd3;

  localparam int TEAM_IDX_W = 8;

  typedef struct packed {
    logic [TEAM_IDX_W-1:0] team;
    logic [1:0]            delta;
  } hist_entry_t;

  function automatic int team_idx_w(input int teams);
    return (teams > 1) ? $clog2(teams) : 1;
  endfunction

endpackage

// File: rtl/score_undo_stack.sv
// score_undo_stack: LIFO ring holding the newest DEPTH history entries.
// A push onto a full stack overwrites the oldest entry.
//   clk, rst    : clock, async active-high reset
//   clear_i     : synchronous empty (wins over push/pop)
//   push_i      : store entry_i as the new top
//   pop_i       : drop the top entry (ignored when empty or pushing)
//   top_o       : current top entry (valid when !empty_o)
//   empty_o     : no entries held
module score_undo_stack
  import score_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = hist_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear_i,
  input  logic   push_i,
  input  logic   pop_i,
  input  entry_t entry_i,
  output entry_t top_o,
  output logic   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  // wr_ptr_q wraps naturally (DEPTH is a power of two), so the oldest
  // entry is simply the next one written once the count saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (push_i) begin
      wr_ptr_q <= wr_ptr_q + PW'(1);
      if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
    end else if (pop_i && count_q != '0) begin
      wr_ptr_q <= wr_ptr_q - PW'(1);
      count_q  <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign top_o   = mem_q[wr_ptr_q - PW'(1)];
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/score_board_mt.sv
// score_board_mt: parametrised multi-team saturating score register with
// per-team status and an optional bounded undo history.
// Undo history is built only when SCORE_BOARD_UNDO_EN is defined; otherwise
// undo is ignored and undo_empty is tied high. Ports are identical in both.
//   clk, rst            : clock, async active-high reset
//   clear               : synchronous clear of scores and history
//   add_valid/team/pts  : scoring event (pts 0 = no-op)
//   undo                : revert most recent recorded event
//   scores              : packed scores, team i at [i*SCORE_W +: SCORE_W]
//   at_max              : per-team score == MAX_SCORE
//   leader, tie         : highest-score team (lowest index on ties), tie flag
//   undo_empty          : no history available
module score_board_mt
  import score_pkg::*;
#(
  parameter  int TEAMS      = 2,
  parameter  int SCORE_W    = 7,
  parameter  int MAX_SCORE  = 2**SCORE_W - 1,
  parameter  int UNDO_DEPTH = 8,
  localparam int TW         = team_idx_w(TEAMS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     add_valid,
  input  logic [TW-1:0]            add_team,
  input  logic [1:0]               add_pts,
  input  logic                     undo,
  output logic [TEAMS*SCORE_W-1:0] scores,
  output logic [TEAMS-1:0]         at_max,
  output logic [TW-1:0]            leader,
  output logic                     tie,
  output logic                     undo_empty
);

  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(MAX_SCORE);

  logic [SCORE_W-1:0]    scores_q [TEAMS];
  logic [SCORE_W-1:0]    scores_d [TEAMS];

  logic [TEAMS-1:0]      team_sel;
  logic [SCORE_W-1:0]    cur_score;
  logic [SCORE_W-1:0]    pts_val;
  logic [SCORE_W-1:0]    headroom;
  logic [1:0]            delta;
  logic                  add_ok;
  logic                  push_ok;
  logic                  do_pop;
  logic [TEAM_IDX_W-1:0] pop_team;
  logic [1:0]            pop_delta;

  // Out-of-range team indices select nothing, which also rejects the add.
  always_comb begin
    team_sel  = '0;
    cur_score = '0;
    for (int i = 0; i < TEAMS; i++) begin
      if (add_team == TW'(i)) begin
        team_sel[i] = 1'b1;
        cur_score   = scores_q[i];
      end
    end
  end

  always_comb begin
    case (add_pts)
      PTS_ONE:   pts_val = SCORE_W'(1);
      PTS_TWO:   pts_val = SCORE_W'(2);
      PTS_THREE: pts_val = SCORE_W'(3);
      default:   pts_val = '0;
    endcase
  end

  assign add_ok   = add_valid && (add_pts != PTS_NONE) && (|team_sel);
  assign headroom = MAX_V - cur_score;
  // Clip to remaining headroom so the score lands exactly on MAX_SCORE.
  assign delta    = (headroom < pts_val) ? headroom[1:0] : add_pts;
  assign push_ok  = add_ok && (delta != 2'd0);

`ifdef SCORE_BOARD_UNDO_EN
  hist_entry_t push_entry;
  hist_entry_t top_entry;
  logic        hist_empty;

  // Any add_valid blocks undo, even when the add itself is rejected.
  assign do_pop     = undo && !add_valid && !hist_empty && !clear;
  assign push_entry = '{team: TEAM_IDX_W'(add_team), delta: delta};

  score_undo_stack #(
    .DEPTH   (UNDO_DEPTH),
    .entry_t (hist_entry_t)
  ) u_hist (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push_ok && !clear),
    .pop_i   (do_pop),
    .entry_i (push_entry),
    .top_o   (top_entry),
    .empty_o (hist_empty)
  );

  assign pop_team   = top_entry.team;
  assign pop_delta  = top_entry.delta;
  assign undo_empty = hist_empty;
`else
  logic [1:0] unused_nohist;

  assign unused_nohist = {undo, push_ok};
  assign do_pop        = 1'b0;
  assign pop_team      = '0;
  assign pop_delta     = '0;
  assign undo_empty    = 1'b1;
`endif

  always_comb begin
    for (int i = 0; i < TEAMS; i++) scores_d[i] = scores_q[i];
    if (clear) begin
      for (int i = 0; i < TEAMS; i++) scores_d[i] = '0;
    end else if (add_ok) begin
      for (int i = 0; i < TEAMS; i++)
        if (team_sel[i]) scores_d[i] = scores_q[i] + SCORE_W'(delta);
    end else if (do_pop) begin
      // Popped delta was applied exactly, so the subtraction cannot underflow.
      for (int i = 0; i < TEAMS; i++)
        if (pop_team == TEAM_IDX_W'(i)) scores_d[i] = scores_q[i] - SCORE_W'(pop_delta);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TEAMS; i++) scores_q[i] <= '0;
    end else begin
      for (int i = 0; i < TEAMS; i++) scores_q[i] <= scores_d[i];
    end
  end

  // Status is purely combinational from the registered scores.
  always_comb begin
    logic [SCORE_W-1:0] best;
    scores = '0;
    at_max = '0;
    leader = '0;
    tie    = 1'b0;
    best   = scores_q[0];
    for (int i = 0; i < TEAMS; i++) begin
      scores[i*SCORE_W +: SCORE_W] = scores_q[i];
      at_max[i] = (scores_q[i] == MAX_V);
    end
    // Strictly-greater keeps the lowest index on ties; a new best clears tie.
    for (int i = 1; i < TEAMS; i++) begin
      if (scores_q[i] > best) begin
        best   = scores_q[i];
        leader = TW'(i);
        tie    = 1'b0;
      end else if (scores_q[i] == best) begin
        tie = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_score_board_mt.sv
module tb_score_board_mt;

  localparam int TEAMS = 3;
  localparam int SW    = 7;
  localparam int MAXS  = 10;
  localparam int DEPTH = 4;
  localparam int TW    = 2;
`ifdef SCORE_BOARD_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic                  add_valid;
  logic [TW-1:0]         add_team;
  logic [1:0]            add_pts;
  logic                  undo;
  logic [TEAMS*SW-1:0]   scores;
  logic [TEAMS-1:0]      at_max;
  logic [TW-1:0]         leader;
  logic                  tie;
  logic                  undo_empty;

  int nvec = 0;
  int nerr = 0;

  // Reference model: plain integer scores and a history of events.
  int m_sc [TEAMS];
  int h_team [$];
  int h_d [$];

  always #5 clk = ~clk;

  score_board_mt #(
    .TEAMS(TEAMS), .SCORE_W(SW), .MAX_SCORE(MAXS), .UNDO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .add_valid(add_valid),
    .add_team(add_team), .add_pts(add_pts), .undo(undo),
    .scores(scores), .at_max(at_max), .leader(leader), .tie(tie),
    .undo_empty(undo_empty)
  );

  task automatic model_reset();
    for (int i = 0; i < TEAMS; i++) m_sc[i] = 0;
    h_team.delete();
    h_d.delete();
  endtask

  task automatic model_step(input bit c, input bit av, input int tm, input int pt, input bit un);
    int d;
    if (c) begin
      model_reset();
    end else if (av && pt != 0 && tm < TEAMS) begin
      d = (MAXS - m_sc[tm] < pt) ? MAXS - m_sc[tm] : pt;
      m_sc[tm] += d;
      if (d > 0) begin
        h_team.push_back(tm);
        h_d.push_back(d);
        if (h_d.size() > DEPTH) begin
          void'(h_team.pop_front());
          void'(h_d.pop_front());
        end
      end
    end else if (!av && un && UNDO_EN && h_d.size() > 0) begin
      m_sc[h_team.pop_back()] -= h_d.pop_back();
    end
  endtask

  task automatic check_all(input string tag);
    int best, lead, cnt;
    logic [SW-1:0] got;
    best = m_sc[0];
    lead = 0;
    for (int i = 1; i < TEAMS; i++)
      if (m_sc[i] > best) begin best = m_sc[i]; lead = i; end
    cnt = 0;
    for (int i = 0; i < TEAMS; i++) if (m_sc[i] == best) cnt++;
    for (int i = 0; i < TEAMS; i++) begin
      got = scores[i*SW +: SW];
      nvec++;
      assert (got === SW'(m_sc[i])) else begin
        nerr++;
        $error("FAIL %s score%0d got %0d exp %0d", tag, i, got, m_sc[i]);
      end
      nvec++;
      assert (at_max[i] === (m_sc[i] == MAXS)) else begin
        nerr++;
        $error("FAIL %s at_max%0d got %b exp %b", tag, i, at_max[i], m_sc[i] == MAXS);
      end
    end
    nvec++;
    assert (leader === TW'(lead)) else begin
      nerr++;
      $error("FAIL %s leader got %0d exp %0d", tag, leader, lead);
    end
    nvec++;
    assert (tie === (cnt >= 2)) else begin
      nerr++;
      $error("FAIL %s tie got %b exp %b", tag, tie, cnt >= 2);
    end
    nvec++;
    assert (undo_empty === (!UNDO_EN || h_d.size() == 0)) else begin
      nerr++;
      $error("FAIL %s undo_empty got %b exp %b", tag, undo_empty, !UNDO_EN || h_d.size() == 0);
    end
  endtask

  task automatic step(input string tag, input bit c, input bit av, input int tm, input int pt, input bit un);
    @(negedge clk);
    clear     = c;
    add_valid = av;
    add_team  = TW'(tm);
    add_pts   = 2'(pt);
    undo      = un;
    @(posedge clk);
    model_step(c, av, tm, pt, un);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; clear = 0; add_valid = 0; add_team = 0; add_pts = 0; undo = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic adds and leader
    step("add_t1_3", 0, 1, 1, 3, 0);
    step("add_t0_2", 0, 1, 0, 2, 0);

    // Saturation at MAX_SCORE=10
    step("clr1", 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step("to9", 0, 1, 0, 3, 0);
    step("sat_add3", 0, 1, 0, 3, 0);
    step("sat_add2", 0, 1, 0, 2, 0);
    step("sat_undo", 0, 0, 0, 0, 1);

    // History depth overwrite
    step("clr2", 1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) step("ten_adds", 0, 1, 0, 1, 0);
    for (int k = 0; k < 5; k++) step("undo_seq", 0, 0, 0, 0, 1);

    // Add and undo in the same cycle
    step("pre_same", 0, 1, 2, 2, 0);
    step("same_cyc", 0, 1, 1, 1, 1);
    step("same_pop", 0, 0, 0, 0, 1);

    // Three-team tie and rejected adds
    step("clr3", 1, 0, 0, 0, 0);
    step("t0_3", 0, 1, 0, 3, 0);
    step("t0_2", 0, 1, 0, 2, 0);
    step("t1_3", 0, 1, 1, 3, 0);
    step("t1_2", 0, 1, 1, 2, 0);
    step("t2_2", 0, 1, 2, 2, 0);
    step("bad_team", 0, 1, 3, 3, 0);
    step("pts0", 0, 1, 1, 0, 0);
    step("pts0_undo", 0, 1, 1, 0, 1);

    // Clear wins over add and undo
    step("clr4", 1, 0, 0, 0, 0);
    step("s4a", 0, 1, 0, 3, 0);
    step("s4b", 0, 1, 0, 1, 0);
    step("s7a", 0, 1, 1, 3, 0);
    step("s7b", 0, 1, 1, 3, 0);
    step("s7c", 0, 1, 1, 1, 0);
    step("clr_all", 1, 1, 1, 2, 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      bit c, av, un;
      int tm, pt;
      c  = ($urandom_range(0, 49) == 0);
      av = ($urandom_range(0, 2) != 0);
      tm = $urandom_range(0, 3);
      pt = $urandom_range(0, 3);
      un = ($urandom_range(0, 1) == 1);
      step("rand", c, av, tm, pt, un);
    end

    // Asynchronous reset mid-stream
    step("pre_rst", 0, 1, 2, 3, 0);
    @(negedge clk);
    clear = 0; add_valid = 0; undo = 0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 0, 1, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
